spram_readback: RTL and testbench

Sequential read-back engine for the single-port RAM that the stream writer fills one word per clock. On a start command it drives the RAM address port through a contiguous, wrapping address range and returns each word on a valid/ready output stream. A two-entry output buffer absorbs the RAM's one-cycle read latency, so downstream backpressure never drops or duplicates a word. It sits between the RAM and any consumer that drains captured data.

---
 rtl/spram_readback_if.sv | 30 +++
 rtl/spram_readback.sv | 132 +++++++++++++
 tb/tb_spram_readback.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_readback_if.sv
`default_nettype none
// ============================================================================
// Module      : spram_readback_if
// Description : Valid/ready output stream carrying words read back from the
//               single-port RAM, with the final word of a command marked.
// Revision    : 1.0 - initial release
// ============================================================================
interface spram_readback_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/spram_readback.sv
`default_nettype none
// ============================================================================
// Module      : spram_readback
// Description : Reads a contiguous, wrapping address range from a registered
//               single-port RAM and streams the words out via a 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_readback #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire                  clock,
    input  wire                  reset_n,
    input  wire                  start,
    input  wire [DEPTH-1:0]      start_addr,
    input  wire [DEPTH:0]        length,
    output logic                 busy,
    output logic                 done,
    output logic [DEPTH-1:0]     ram_addr,
    output logic                 ram_we,
    input  wire [WIDTH-1:0]      ram_rdata,
    spram_readback_if.master     out_stream
);

    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_read  = 2'd1;
    localparam logic [1:0]       c_st_drain = 2'd2;
    localparam logic [DEPTH:0]   c_cnt_zero = '0;
    localparam logic [DEPTH:0]   c_cnt_one  = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] c_addr_one = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [DEPTH-1:0] r_addr;
    logic [DEPTH-1:0] r_last_addr;
    logic [DEPTH:0]   r_issue;
    logic [DEPTH:0]   r_remain;
    logic             r_inflight;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_fifo [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_valid;
    logic             w_pop;
    logic [1:0]       w_occ;
    logic             w_issue;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & out_stream.out_ready;
    // Entries held after this edge; also the space test for issuing a read,
    // so a pop in the same cycle frees room and sustains one word per clock.
    assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue = (r_state == c_st_read) && (r_issue != c_cnt_zero) && (w_occ < 2'd2);

    assign ram_addr = w_issue ? r_addr : r_last_addr;
    assign ram_we   = 1'b0;
    assign busy     = r_busy;
    assign done     = r_done;

    assign out_stream.out_data  = r_fifo[r_rd_ptr];
    assign out_stream.out_valid = w_valid;
    assign out_stream.out_last  = w_valid && (r_remain == c_cnt_one);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_issue     <= '0;
            r_remain    <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (length != c_cnt_zero) begin
                            r_addr   <= start_addr;
                            r_issue  <= length;
                            r_remain <= length;
                            r_busy   <= 1'b1;
                            r_state  <= c_st_read;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_read: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + c_addr_one;
                        r_last_addr <= r_addr;
                        r_issue     <= r_issue - c_cnt_one;
                        if (r_issue == c_cnt_one) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_pop && (r_remain == c_cnt_one)) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // RAM data is valid the cycle after its address was presented
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= ram_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_remain <= r_remain - c_cnt_one;
            end
            r_count <= w_occ;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_readback.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_readback
// Description : Directed self-checking bench for spram_readback with a
//               registered RAM model preloaded with mem[i] = i + 0x10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_readback;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_rdata;
    logic [7:0] mem [16];

    spram_readback_if #(.WIDTH(8)) bus ();

    spram_readback #(.WIDTH(8), .DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .out_stream (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ram_rdata <= mem[ram_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] q_data[$];
    logic       q_last[$];
    logic [3:0] q_addr[$];
    int         done_cnt;
    int         done_cyc;
    int         first_valid_cyc;
    int         last_hs_cyc;
    int         stall_err;
    logic       prev_stall;
    logic [7:0] prev_data;

    // Observer sampled on the falling edge, away from the active clock edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                q_data.push_back(bus.out_data);
                q_last.push_back(bus.out_last);
                last_hs_cyc = cyc;
            end
            if (busy && (q_addr.size() == 0 || q_addr[q_addr.size()-1] != ram_addr))
                q_addr.push_back(ram_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    end

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_addr.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        stall_err       = 0;
    endtask

    task automatic do_start(input logic [3:0] a, input logic [4:0] n, output int t0);
        @(posedge clock); #1;
        start = 1'b1; start_addr = a; length = n;
        @(posedge clock); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(posedge clock); #1;
            n++;
        end
        if (done_cnt == 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic check_stream(input string name, input logic [3:0] a, input int n);
        logic [7:0] got;
        logic       gl;
        checks++;
        if (q_data.size() != n) begin
            failures++;
            $display("FAIL %s_count: got %0d words, expected %0d", name, q_data.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            got = (i < q_data.size()) ? q_data[i] : 8'hxx;
            gl  = (i < q_last.size()) ? q_last[i] : 1'bx;
            checks++;
            if (got !== 8'(((32'(a) + i) % 16) + 16)) begin
                failures++;
                $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got,
                         8'(((32'(a) + i) % 16) + 16));
            end
            checks++;
            if (gl !== (i == n - 1)) begin
                failures++;
                $display("FAIL %s_last[%0d]: got %b expected %b", name, i, gl, (i == n - 1));
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
        checks++; if (ram_addr !== 4'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", ram_we); end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int t0;
        clear_mon();
        do_start(4'd2, 5'd4, t0);
        wait_done(40, "basic");
        check_stream("basic", 4'd2, 4);
        checks++;
        if (first_valid_cyc - t0 != 2) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 2", first_valid_cyc - t0);
        end
        checks++;
        if (last_hs_cyc - t0 != 5) begin
            failures++;
            $display("FAIL basic_throughput: got %0d expected 5", last_hs_cyc - t0);
        end
        checks++;
        if (done_cyc - last_hs_cyc != 1) begin
            failures++;
            $display("FAIL basic_done_timing: got %0d expected 1", done_cyc - last_hs_cyc);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        int t0;
        logic [3:0] exp_a [4];
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        clear_mon();
        do_start(4'd14, 5'd4, t0);
        wait_done(40, "wrap");
        check_stream("wrap", 4'd14, 4);
        checks++;
        if (q_addr.size() != 4) begin
            failures++;
            $display("FAIL wrap_addr_count: got %0d expected 4", q_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q_addr.size() || q_addr[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i,
                         (i < q_addr.size()) ? q_addr[i] : 4'hx, exp_a[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t0;
        int k = 0;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        clear_mon();
        do_start(4'd5, 5'd6, t0);
        while (done_cnt == 0 && k < 200) begin
            @(posedge clock); #1;
            bus.out_ready = pat[k % 6];
            k++;
        end
        bus.out_ready = 1'b1;
        wait_done(5, "backpressure");
        check_stream("backpressure", 4'd5, 6);
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL backpressure_stable: got %0d unstable cycles expected 0", stall_err);
        end
    endtask

    task automatic test_full_depth();
        int t0;
        clear_mon();
        do_start(4'd3, 5'd16, t0);
        wait_done(80, "full");
        check_stream("full", 4'd3, 16);
        checks++;
        if (last_hs_cyc - t0 != 17) begin
            failures++;
            $display("FAIL full_throughput: got %0d expected 17", last_hs_cyc - t0);
        end
    endtask

    task automatic test_zero_length();
        int t0;
        clear_mon();
        do_start(4'd7, 5'd0, t0);
        @(negedge clock);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b expected 0", busy); end
        repeat (4) @(negedge clock);
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (first_valid_cyc != -1) begin failures++; $display("FAIL zero_valid: got valid at %0d expected none", first_valid_cyc); end
    endtask

    task automatic test_start_while_busy();
        int t0;
        clear_mon();
        do_start(4'd2, 5'd5, t0);
        @(posedge clock); #1;
        start = 1'b1; start_addr = 4'd9; length = 5'd3;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(40, "busy_start");
        repeat (6) @(posedge clock);
        #1;
        check_stream("busy_start", 4'd2, 5);
    endtask

    task automatic test_reset_mid();
        int t0;
        int n = 0;
        clear_mon();
        do_start(4'd6, 5'd5, t0);
        while (q_data.size() < 2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h expected 00", bus.out_data); end
        checks++; if (ram_addr !== 4'd0) begin failures++; $display("FAIL midrst_addr: got %0d expected 0", ram_addr); end
        repeat (5) @(negedge clock);
        checks++;
        if (done_cnt != 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
        clear_mon();
        do_start(4'd0, 5'd2, t0);
        wait_done(40, "midrst_restart");
        check_stream("midrst_restart", 4'd0, 2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
        reset_n       = 1'b0;
        start         = 1'b0;
        start_addr    = 4'd0;
        length        = 5'd0;
        bus.out_ready = 1'b1;
        clear_mon();
        prev_stall    = 1'b0;
        prev_data     = 8'h00;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_full_depth();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
